// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array datapath.
// Used by the feeder and the array so both agree on element width and drain length.
package systolic_pkg;

  localparam int SYS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  // Cycles for the last activation to traverse both skew and array columns.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Weight and activation handshake channels into the systolic feeder.
// master = upstream producer, slave = feeder.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = systolic_pkg::SYS_DATA_WIDTH,
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4
);

  logic                                                w_valid;
  logic                                                w_ready;
  logic [ARRAY_ROWS-1:0][ARRAY_COLS-1:0][DATA_WIDTH-1:0] w_data;
  logic                                                a_valid;
  logic                                                a_ready;
  logic [ARRAY_ROWS-1:0][DATA_WIDTH-1:0]               a_data;
  logic                                                a_last;

  modport master (
    output w_valid, w_data, a_valid, a_data, a_last,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, a_last,
    output w_ready, a_ready
  );

endinterface

// File: rtl/systolic_skew_line.sv
// One lane's delay chain: {valid, data} shifted through DEPTH registers.
// Synchronous active-low reset flushes everything in flight.
module systolic_skew_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic [DATA_WIDTH-1:0] head_data,
  output logic                  tail_valid,
  output logic [DATA_WIDTH-1:0] tail_data
);

  logic [DEPTH:1]                 vld_pipe;
  logic [DEPTH:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= head_valid;
      dat_pipe[1] <= head_data;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign tail_valid = vld_pipe[DEPTH];
  assign tail_data  = dat_pipe[DEPTH];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the systolic array: latches a weight matrix, pulses the load,
// streams activations with a per-lane diagonal skew, then drains the tile.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4,
  parameter int CNT_W      = $clog2(ARRAY_ROWS + ARRAY_COLS) + 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  systolic_feeder_if.slave                                     feed,
  output logic                                                 weights_load,
  output logic [ARRAY_ROWS-1:0][ARRAY_COLS-1:0][DATA_WIDTH-1:0] weight_data,
  output logic [ARRAY_ROWS-1:0][DATA_WIDTH-1:0]                array_data,
  output logic [ARRAY_ROWS-1:0]                                array_valid,
  output logic                                                 busy,
  output logic                                                 drain_done
);

  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(drain_cycles(ARRAY_ROWS, ARRAY_COLS));

  feeder_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             w_fire, a_fire;

  assign w_fire = feed.w_valid && feed.w_ready;
  assign a_fire = feed.a_valid && feed.a_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      weight_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (w_fire) weight_data <= feed.w_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    feed.w_ready = 1'b0;
    feed.a_ready = 1'b0;
    weights_load = 1'b0;
    drain_done   = 1'b0;
    case (state)
      IDLE: begin
        feed.w_ready = 1'b1;
        if (feed.w_valid) state_nxt = LOAD;
      end
      LOAD: begin
        weights_load = 1'b1;
        state_nxt    = STREAM;
      end
      STREAM: begin
        feed.a_ready = 1'b1;
        if (feed.a_valid && feed.a_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_LEN;
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - CNT_W'(1);
        // Counter hits zero on this edge: final drain cycle.
        if (cnt <= CNT_W'(1)) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bubbles and drain cycles inject zeros with valid low at every lane head.
  for (genvar j = 0; j < ARRAY_ROWS; j++) begin : g_lane
    logic [DATA_WIDTH-1:0] head_data;
    assign head_data = a_fire ? feed.a_data[j] : '0;

    systolic_skew_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (j + 1)
    ) u_line (
      .clk        (clk),
      .rst_n      (rst_n),
      .head_valid (a_fire),
      .head_data  (head_data),
      .tail_valid (array_valid[j]),
      .tail_data  (array_data[j])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected lane/weight/drain
// events with their due cycle; a negedge monitor pops and compares.
module tb_systolic_feeder;
  localparam int DW    = 32;
  localparam int R     = 4;
  localparam int C     = 4;
  localparam int CNT_W = $clog2(R + C) + 1;
  localparam int DRAIN = R + C - 1;

  typedef logic [R-1:0][C-1:0][DW-1:0] mat_t;
  typedef logic [R-1:0][DW-1:0]        vec_t;
  typedef struct { int cyc; logic [DW-1:0] d; } lane_exp_t;
  typedef struct { int cyc; mat_t m; }          w_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_WIDTH(DW), .ARRAY_ROWS(R), .ARRAY_COLS(C)) feed();

  logic         weights_load, busy, drain_done;
  mat_t         weight_data;
  vec_t         array_data;
  logic [R-1:0] array_valid;

  systolic_feeder #(
    .DATA_WIDTH(DW), .ARRAY_ROWS(R), .ARRAY_COLS(C), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .feed         (feed),
    .weights_load (weights_load),
    .weight_data  (weight_data),
    .array_data   (array_data),
    .array_valid  (array_valid),
    .busy         (busy),
    .drain_done   (drain_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  lane_exp_t lq[R][$];
  w_exp_t    wq[$];
  int        dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_m(input bit ok, input string name, input mat_t act, input mat_t exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < R; j++) v[j] = $urandom;
    return v;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = $urandom;
    return m;
  endfunction

  // ---------------- monitor ----------------
  lane_exp_t mon_le;
  w_exp_t    mon_we;
  int        mon_de;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int j = 0; j < R; j++) begin
        if (array_valid[j]) begin
          if (lq[j].size() == 0) chk(1'b0, "lane_spurious_valid", longint'(j), -1);
          else begin
            mon_le = lq[j].pop_front();
            chk(cyc == mon_le.cyc, "lane_timing", longint'(cyc), longint'(mon_le.cyc));
            chk(array_data[j] == mon_le.d, "lane_data", longint'(array_data[j]), longint'(mon_le.d));
          end
        end else begin
          if (lq[j].size() > 0 && lq[j][0].cyc <= cyc) begin
            mon_le = lq[j].pop_front();
            chk(1'b0, "lane_missing_valid", longint'(j), longint'(mon_le.cyc));
          end
          chk(array_data[j] == '0, "lane_idle_zero", longint'(array_data[j]), 0);
        end
      end
      if (weights_load) begin
        if (wq.size() == 0) chk(1'b0, "weights_load_spurious", 1, 0);
        else begin
          mon_we = wq.pop_front();
          chk(cyc == mon_we.cyc, "weights_load_timing", longint'(cyc), longint'(mon_we.cyc));
          chk_m(weight_data == mon_we.m, "weight_data", weight_data, mon_we.m);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        mon_we = wq.pop_front();
        chk(1'b0, "weights_load_missing", 0, longint'(mon_we.cyc));
      end
      if (drain_done) begin
        if (dq.size() == 0) chk(1'b0, "drain_done_spurious", 1, 0);
        else begin
          mon_de = dq.pop_front();
          chk(cyc == mon_de, "drain_done_timing", longint'(cyc), longint'(mon_de));
        end
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        mon_de = dq.pop_front();
        chk(1'b0, "drain_done_missing", 0, longint'(mon_de));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) tick();
    @(negedge clk);
  endtask

  task automatic send_weights(input mat_t m, output int acc);
    int n = 0;
    acc = -1;
    feed.w_valid = 1'b1;
    feed.w_data  = m;
    while (acc < 0 && n < 100) begin
      @(negedge clk);
      if (feed.w_ready) begin
        acc = cyc;
        wq.push_back('{cyc + 1, m});
      end else begin
        n++;
        tick();
      end
    end
    if (acc < 0) chk(1'b0, "w_ready_timeout", 0, 1);
    tick();
    feed.w_valid = 1'b0;
    feed.w_data  = rand_mat();
  endtask

  task automatic send_vec(input vec_t v, input bit last, output int acc);
    int n = 0;
    acc = -1;
    feed.a_valid = 1'b1;
    feed.a_data  = v;
    feed.a_last  = last;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (feed.a_ready) begin
        acc = cyc;
        chk(feed.w_ready == 1'b0, "w_ready_while_streaming", longint'(feed.w_ready), 0);
        for (int j = 0; j < R; j++) lq[j].push_back('{cyc + 1 + j, v[j]});
        if (last) dq.push_back(cyc + DRAIN);
      end else begin
        n++;
        tick();
      end
    end
    if (acc < 0) chk(1'b0, "a_ready_timeout", 0, 1);
    tick();
    // Junk on data/last while not offered must be ignored.
    feed.a_valid = 1'b0;
    feed.a_data  = rand_vec();
    feed.a_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_tile(input int nvec, output int last_acc);
    int acc;
    last_acc = -1;
    for (int i = 0; i < nvec; i++) begin
      if ($urandom_range(0, 2) == 0) tick();
      send_vec(rand_vec(), i == nvec - 1, acc);
      last_acc = acc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   wa, acc_s, acc0, acc1, acc2, wacc2, last_b, wacc3, last_c, wd, last_d;
    mat_t m0;
    vec_t skew_v;

    feed.w_valid = 1'b0;
    feed.w_data  = '0;
    feed.a_valid = 1'b0;
    feed.a_data  = '0;
    feed.a_last  = 1'b0;
    rst_n        = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk(feed.w_ready == 1'b1, "reset_w_ready", longint'(feed.w_ready), 1);
      chk(feed.a_ready == 1'b0, "reset_a_ready", longint'(feed.a_ready), 0);
      chk(array_valid == '0, "reset_array_valid", longint'(array_valid), 0);
      chk(busy == 1'b0, "reset_busy", longint'(busy), 0);
      chk_m(weight_data == '0, "reset_weight_data", weight_data, '0);
      tick();
    end

    // Weight load with w_data[r][c] = 16*r+c
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m0[r][c] = DW'(16 * r + c);
    send_weights(m0, wa);
    @(negedge clk);
    chk(weight_data[2][3] == 32'h23, "weight_2_3", longint'(weight_data[2][3]), 'h23);
    chk(busy == 1'b1, "busy_in_load", longint'(busy), 1);

    // Skew vector; accepted on the cycle after LOAD
    for (int j = 0; j < R; j++) skew_v[j] = DW'(32'h10 + j);
    send_vec(skew_v, 1'b0, acc_s);
    chk(acc_s == wa + 2, "first_a_ready_cycle", longint'(acc_s), longint'(wa + 2));

    // Stream with bubble and last, while a second matrix waits on w_ready
    m0 = rand_mat();
    fork
      begin
        send_vec(rand_vec(), 1'b0, acc0);
        send_vec(rand_vec(), 1'b0, acc1);
        tick();
        send_vec(rand_vec(), 1'b1, acc2);
        chk(acc1 == acc0 + 1, "back_to_back_accept", longint'(acc1), longint'(acc0 + 1));
        chk(acc2 == acc1 + 2, "accept_after_bubble", longint'(acc2), longint'(acc1 + 2));
        @(negedge clk);
        chk(feed.a_ready == 1'b0, "a_ready_in_drain", longint'(feed.a_ready), 0);
        chk(busy == 1'b1, "busy_in_drain", longint'(busy), 1);
        wait_cycle(acc2 + DRAIN);
        chk(feed.w_ready == 1'b0, "w_ready_at_drain_done", longint'(feed.w_ready), 0);
        wait_cycle(acc2 + DRAIN + 1);
        chk(feed.w_ready == 1'b1, "w_ready_after_drain", longint'(feed.w_ready), 1);
        chk(busy == 1'b0, "idle_after_drain", longint'(busy), 0);
      end
      begin
        send_weights(m0, wacc2);
      end
    join
    chk(wacc2 == acc2 + DRAIN + 1, "held_weights_accept", longint'(wacc2), longint'(acc2 + DRAIN + 1));

    // Random tile, then immediately offered next matrix
    run_tile(5, last_b);
    send_weights(rand_mat(), wacc3);
    chk(wacc3 == last_b + DRAIN + 1, "tile_turnaround", longint'(wacc3), longint'(last_b + DRAIN + 1));

    // Reset two cycles into DRAIN
    run_tile(3, last_c);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < R; j++) lq[j].delete();
    wq.delete();
    dq.delete();
    @(negedge clk);
    chk(array_valid == '0, "midreset_array_valid", longint'(array_valid), 0);
    chk(busy == 1'b0, "midreset_busy", longint'(busy), 0);
    chk(drain_done == 1'b0, "midreset_drain_done", longint'(drain_done), 0);
    chk(feed.w_ready == 1'b1, "midreset_w_ready", longint'(feed.w_ready), 1);
    chk(feed.a_ready == 1'b0, "midreset_a_ready", longint'(feed.a_ready), 0);
    chk_m(weight_data == '0, "midreset_weight_data", weight_data, '0);
    repeat (10) tick();

    // Recovery tile
    send_weights(rand_mat(), wd);
    run_tile(4, last_d);
    wait_cycle(last_d + DRAIN + 4);
    for (int j = 0; j < R; j++)
      chk(lq[j].size() == 0, "lane_queue_drained", longint'(lq[j].size()), 0);
    chk(wq.size() == 0, "weights_queue_drained", longint'(wq.size()), 0);
    chk(dq.size() == 0, "drain_queue_drained", longint'(dq.size()), 0);
    chk(busy == 1'b0, "final_idle", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
